// File: rtl/param_assoc_cache.sv
// N-way set-associative write-back, write-allocate line cache with true-LRU ages.
// Full-line reads and writes on the request side, with a line-wide memory port behind it.
module param_assoc_cache #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned SETS   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [LINE_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic              resp_hit_o,
  output logic [LINE_W-1:0] resp_rdata_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [LINE_W-1:0] mem_req_wdata_o,
  input  logic              mem_resp_valid_i,
  input  logic [LINE_W-1:0] mem_resp_rdata_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned AGE_W = $clog2(WAYS);

  typedef enum logic [2:0] {StIdle, StLookup, StEvict, StRefill, StRespond} state_e;

  state_e state_q;

  // Line storage has no reset; valid/dirty/age carry all the state that matters.
  logic [LINE_W-1:0] data_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]             valid_q;
  logic [SETS-1:0][WAYS-1:0]             dirty_q;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]  age_q;

  logic              req_we_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic [IDX_W-1:0]  req_idx_q;
  logic [LINE_W-1:0] req_wdata_q;
  logic [AGE_W-1:0]  way_q;
  logic              rd_acc_q;

  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_hit_q;
  logic [LINE_W-1:0] resp_rdata_q;
  logic              mem_req_valid_q;
  logic              mem_req_we_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic [LINE_W-1:0] mem_req_wdata_q;
  logic [31:0]       hit_cnt_q;
  logic [31:0]       miss_cnt_q;

  logic unused_off;
  assign unused_off = ^req_addr_i[OFF_W-1:0];

  // Tag compare and victim selection for the latched index.
  logic             hit;
  logic [AGE_W-1:0] hit_way;
  logic [AGE_W-1:0] victim_way;
  logic             victim_dirty;

  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (age_q[req_idx_q][w] == AGE_W'(WAYS - 1)) begin
        victim_way = AGE_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins over the oldest way.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[req_idx_q][w]) begin
        victim_way = AGE_W'(w);
      end
    end
    victim_dirty = valid_q[req_idx_q][victim_way] && dirty_q[req_idx_q][victim_way];
  end

  // Line write port: refill install or requester line write.
  logic              line_we;
  logic [LINE_W-1:0] line_wdata;

  always_comb begin
    line_we    = 1'b0;
    line_wdata = '0;
    if (state_q == StRefill && rd_acc_q && mem_resp_valid_i) begin
      line_we    = 1'b1;
      line_wdata = mem_resp_rdata_i;
    end else if (state_q == StRespond && req_we_q) begin
      line_we    = 1'b1;
      line_wdata = req_wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[req_idx_q][way_q] <= line_wdata;
      tag_q[req_idx_q][way_q]  <= req_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      valid_q         <= '0;
      dirty_q         <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          age_q[s][w] <= AGE_W'(w);
        end
      end
      req_we_q        <= 1'b0;
      req_tag_q       <= '0;
      req_idx_q       <= '0;
      req_wdata_q     <= '0;
      way_q           <= '0;
      rd_acc_q        <= 1'b0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            req_we_q    <= req_we_i;
            req_tag_q   <= req_addr_i[ADDR_W-1 -: TAG_W];
            req_idx_q   <= req_addr_i[OFF_W +: IDX_W];
            req_wdata_q <= req_wdata_i;
            req_ready_q <= 1'b0;
            state_q     <= StLookup;
          end
        end

        StLookup: begin
          if (hit) begin
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            way_q        <= hit_way;
            if (!req_we_q) resp_rdata_q <= data_q[req_idx_q][hit_way];
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            state_q      <= StRespond;
          end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            way_q <= victim_way;
            if (victim_dirty) begin
              mem_req_valid_q <= 1'b1;
              mem_req_we_q    <= 1'b1;
              mem_req_addr_q  <= {tag_q[req_idx_q][victim_way], req_idx_q, {OFF_W{1'b0}}};
              mem_req_wdata_q <= data_q[req_idx_q][victim_way];
              state_q         <= StEvict;
            end else if (req_we_q) begin
              resp_valid_q <= 1'b1;
              resp_hit_q   <= 1'b0;
              state_q      <= StRespond;
            end else begin
              mem_req_valid_q <= 1'b1;
              mem_req_we_q    <= 1'b0;
              mem_req_addr_q  <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
              rd_acc_q        <= 1'b0;
              state_q         <= StRefill;
            end
          end
        end

        StEvict: begin
          if (mem_req_ready_i) begin
            mem_req_we_q <= 1'b0;
            if (req_we_q) begin
              mem_req_valid_q <= 1'b0;
              resp_valid_q    <= 1'b1;
              resp_hit_q      <= 1'b0;
              state_q         <= StRespond;
            end else begin
              // Refill request follows immediately; valid stays high.
              mem_req_addr_q <= {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
              rd_acc_q       <= 1'b0;
              state_q        <= StRefill;
            end
          end
        end

        StRefill: begin
          if (!rd_acc_q) begin
            if (mem_req_ready_i) begin
              mem_req_valid_q <= 1'b0;
              rd_acc_q        <= 1'b1;
            end
          end else if (mem_resp_valid_i) begin
            valid_q[req_idx_q][way_q] <= 1'b1;
            dirty_q[req_idx_q][way_q] <= 1'b0;
            resp_rdata_q              <= mem_resp_rdata_i;
            resp_valid_q              <= 1'b1;
            resp_hit_q                <= 1'b0;
            rd_acc_q                  <= 1'b0;
            state_q                   <= StRespond;
          end
        end

        StRespond: begin
          if (req_we_q) begin
            valid_q[req_idx_q][way_q] <= 1'b1;
            dirty_q[req_idx_q][way_q] <= 1'b1;
          end
          for (int w = 0; w < int'(WAYS); w++) begin
            if (age_q[req_idx_q][w] < age_q[req_idx_q][way_q]) begin
              age_q[req_idx_q][w] <= age_q[req_idx_q][w] + AGE_W'(1);
            end
          end
          age_q[req_idx_q][way_q] <= '0;
          resp_valid_q <= 1'b0;
          resp_hit_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o     = req_ready_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_hit_o      = resp_hit_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_we_o    = mem_req_we_q;
  assign mem_req_addr_o  = mem_req_addr_q;
  assign mem_req_wdata_o = mem_req_wdata_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

endmodule
